// File: rtl/shift_reg_pkg.sv
// Mode encodings shared by the universal shift register and its bench.
package shift_reg_pkg;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;
endpackage

// File: rtl/reg_rst_en.sv
// WIDTH-bit register with asynchronous active-high reset and load enable.
module reg_rst_en #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/shift_reg_universal.sv
// Universal register: hold, load, clear, shifts and rotates with serial in/out.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter logic [63:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             zero
);
    logic [WIDTH-1:0] q_next;

    // A single-bit register has no neighbours, so shifts reduce to sin and rotates to q.
    if (WIDTH == 1) begin : g_w1
        always_comb begin
            q_next = q;
            case (mode)
                MODE_LOAD:          q_next = d;
                MODE_SHL, MODE_SHR: q_next = sin;
                MODE_CLR:           q_next = '0;
                default:            q_next = q;
            endcase
        end
    end else begin : g_wn
        always_comb begin
            q_next = q;
            case (mode)
                MODE_HOLD: q_next = q;
                MODE_LOAD: q_next = d;
                MODE_SHL:  q_next = {q[WIDTH-2:0], sin};
                MODE_SHR:  q_next = {sin, q[WIDTH-1:1]};
                MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
                MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
                MODE_CLR:  q_next = '0;
                default:   q_next = q;
            endcase
        end
    end

    reg_rst_en #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE[WIDTH-1:0])
    ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (q_next),
        .q     (q)
    );

    assign so_msb = q[WIDTH-1];
    assign so_lsb = q[0];
    assign zero   = (q == '0);
endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised universal register: a WIDTH-bit storage element that is the clocked, resettable successor to the single-bit level-sensitive storage cell.
- Supports hold, parallel load, clear, logical and arithmetic shifts, and rotates under a mode select, with serial in/out.
- Used as the datapath register for bit-serial units, shifters and lab test scaffolding.

Parameters:
- WIDTH, 8, number of stored bits; legal range 1..64.
- RESET_VALUE, 0, value of q after reset; truncated to WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  update enable; when 0 the register holds regardless of mode.
- mode  input  3  operation select (encodings below).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for SHL/SHR.
- q  output  WIDTH  registered state.
- so_msb  output  1  combinational, equals q[WIDTH-1] (bit lost on a left shift).
- so_lsb  output  1  combinational, equals q[0] (bit lost on a right shift).
- zero  output  1  combinational, 1 iff q == 0.

Behaviour:
- Reset: while reset=1, q = RESET_VALUE immediately (asynchronous, no clock needed) and held. so_msb, so_lsb and zero follow from q.
- Reset deasserting between edges: the first update happens on the next rising edge with reset=0.
- Reset mid-sequence: reset asserted during any operation discards it; no partial update survives.
- Update rule: at a rising edge with reset=0 and en=1, q_next is selected by mode:
  - 000 HOLD: q.
  - 001 LOAD: d.
  - 010 SHL: {q[WIDTH-2:0], sin}.
  - 011 SHR: {sin, q[WIDTH-1:1]} (logical right shift, serial fill).
  - 100 ROL: {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: {q[0], q[WIDTH-1:1]}.
  - 110 ASR: {q[WIDTH-1], q[WIDTH-1:1]} (sign-extending).
  - 111 CLR: all zeros (synchronous clear; distinct from reset and ignores RESET_VALUE).
- en=0: q holds for every mode, including CLR and LOAD.
- Latency: one cycle from inputs sampled at edge N to q valid after edge N; output flags are combinational from q with no extra latency.
- WIDTH=1 boundary:
  - SHL and SHR give q_next = sin.
  - ROL, ROR and ASR give q_next = q.
  - The implementation must not form illegal part-selects at WIDTH=1 (use a generate branch).
- No X propagation from an unused d or sin: q must not take X when mode does not consume that input.
- X in mode or en with reset=0: q becomes X in simulation. This is expected and benches must not rely on it.

Decomposition:
- Shared package shift_reg_pkg holds the 3-bit mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR.
- One sub-module, reg_rst_en:
  - WIDTH-bit flip-flop with asynchronous active-high reset to RESET_VALUE and a load enable.
  - It is the only sequential element.
- The next-state mux is combinational logic in shift_reg_universal.

Test Plan (WIDTH=8, RESET_VALUE=8'hA5 unless noted):
- Reset asserted between edges with no clock -> q=8'hA5 within the same timestep, zero=0. Deassert, en=1, mode=CLR, one edge -> q=8'h00, zero=1.
- LOAD d=8'h81, then SHL sin=1 -> q=8'h03, so_msb=0. Then SHR sin=0 -> q=8'h01, so_lsb=1.
- LOAD 8'h81:
  - ROL -> 8'h03.
  - ROR twice -> 8'hC0.
  - ROL eight times from 8'h81 -> 8'h81 (wrap-around).
- LOAD 8'h90, then ASR -> 8'hC8. ASR three more times -> 8'hF9. Compare SHR sin=0 from 8'h90 -> 8'h48.
- en=0 with mode=LOAD d=8'hFF, then mode=CLR, over several edges -> q unchanged (8'h90). Then en=1 LOAD -> 8'hFF.
- Reset pulsed mid shift sequence (after two SHLs) -> q=8'hA5 immediately. Also with WIDTH=1, RESET_VALUE=0: SHL sin=1 -> q=1, ROL -> q=1, SHR sin=0 -> q=0.
